lsu_align: RTL and testbench
============================

// Module: lsu_align
// PURPOSE
//  Load/store alignment unit, directly upstream of data_mem. Accepts byte-addressed RV32
//  load/store requests (funct3 width, any alignment) and drives data_mem's word-indexed port:
//  wren, is_load, byte mask, word address, pre-shifted write data. Splits misaligned accesses
//  into two word accesses, merges returned words, and sign/zero-extends loads.
// PARAMETERS
//  ADDR_W  32  byte-address width of the request
//  MEM_AW   5  word-index width of data_mem (r_addr/w_addr)
// PORTS
//  clk          in   1       clock; all state on posedge
//  rst          in   1       reset, synchronous, active-high
//  req_valid    in   1       request present
//  req_ready    out  1       unit can accept (high only in IDLE and rst low)
//  req_we       in   1       1 = store, 0 = load
//  req_funct3   in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, right-justified
//  resp_valid   out  1       one-cycle completion pulse
//  resp_rdata   out  32      load result; 0 for stores and errors; held until next pulse
//  resp_err     out  1       illegal funct3; valid with resp_valid
//  mem_wren     out  1       to data_mem wren
//  mem_is_load  out  1       to data_mem is_load
//  mem_mask     out  4       to data_mem mask_buffer; bit i = byte lane i
//  mem_r_addr   out  MEM_AW  word index for reads
//  mem_w_addr   out  MEM_AW  word index for writes
//  mem_w_data   out  32      lane-aligned write data
//  mem_r_data   in   32      data_mem r_data (registered, valid the cycle after is_load)
// BEHAVIOUR
//  - Reset: state IDLE; resp_valid, resp_err, resp_rdata, all mem_* outputs = 0. mem_wren and
//    mem_is_load are gated by !rst, so no memory access on any edge where rst is sampled high.
//    Reset mid-operation aborts; the second half of a split store is not written.
//  - Handshake: accept when req_valid & req_ready; request fields captured in that cycle.
//    No response backpressure. mem_wren and mem_is_load never both high.
//  - Decode: off = addr[1:0]; n = 1/2/4 bytes; word N = addr[MEM_AW+1:2]; split = off+n > 4.
//    m8 = ((1<<n)-1) << off; lo mask = m8[3:0], hi mask = m8[7:4].
//    d64 = {32'b0,wdata} << 8*off; lo data = d64[31:0], hi data = d64[63:32].
//    Word N+1 wraps modulo 2^MEM_AW; address bits above MEM_AW+1 ignored.
//  - FSM: IDLE -> ACC0 -> [ACC1 if split] -> [WAIT if load] -> RESP -> IDLE.
//    Illegal funct3 (011,110,111; 100/101 on store): IDLE -> RESP, resp_err=1, no mem access.
//    ACC0 : store: mem_wren=1, mem_w_addr=N, lo mask/data; load: mem_is_load=1, mem_r_addr=N.
//    ACC1 : store: mem_wren=1, mem_w_addr=N+1, hi mask/data;
//           load: mem_is_load=1, mem_r_addr=N+1; capture mem_r_data into lo buffer.
//    WAIT : capture mem_r_data into lo (unsplit) or hi (split) buffer.
//    RESP : resp_valid=1; load result = ({hi,lo} >> 8*off) truncated to n bytes, sign-extended
//           for B/H, zero-extended for BU/HU/W; hi treated as 0 when unsplit.
//  - Latency (accept cycle = 0, resp_valid cycle): aligned store 2, split store 3,
//    aligned load 3, split load 4, error 1. New request accepted in the cycle after RESP.
//  - mem_mask/mem_w_data/addresses are 0 in states that issue no access.
// TESTING
//  1 SW addr 0x08, wdata 0xDEADBEEF -> ACC0: w_addr=2, mask=1111, w_data=0xDEADBEEF; resp @2.
//  2 SH addr 0x03, wdata 0x0000ABCD -> w_addr=0 mask=1000 data=0xCD000000, then w_addr=1
//    mask=0001 data=0x000000AB; resp @3.
//  3 mem word1=0x11223344: LB addr 0x07 -> 0x00000011; LH addr 0x06 -> 0x00001122;
//    word1=0x80FF0000: LH addr 0x06 -> 0xFFFF80FF, LHU -> 0x000080FF; resp @3 each.
//  4 words0/1=0xAABBCCDD/0x11223344: LW addr 0x02 -> 0x3344AABB, reads 0 then 1; resp @4.
//  5 SW addr 0x7D (MEM_AW=5, N=31) -> second write to w_addr=0 (wrap), mask=0001.
//  6 funct3=011 -> resp_valid+resp_err @1, no wren/is_load; rst in ACC0 of split store ->
//    no write to N+1, req_ready=1 first cycle after rst low.

Source files
------------

// File: rtl/lsu_align.sv
// RV32 load/store alignment unit in front of a word-indexed data memory.
// Misaligned accesses become two word accesses; load results are merged and extended here.
module lsu_align #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_wren,
  output logic              mem_is_load,
  output logic [3:0]        mem_mask,
  output logic [MEM_AW-1:0] mem_r_addr,
  output logic [MEM_AW-1:0] mem_w_addr,
  output logic [31:0]       mem_w_data,
  input  logic [31:0]       mem_r_data
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} state_t;
  state_t state, state_next;

  logic              we_q, err_q, split_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [MEM_AW-1:0] word_q;
  logic [31:0]       wdata_q, lo_q, hi_q, rdata_q;

  logic              req_legal, req_split, accept;
  logic [2:0]        req_n;
  logic [7:0]        size_mask, m8;
  logic [63:0]       d64;
  logic [31:0]       shifted, load_result;
  logic              unused_addr;

  // Address bits above the word index do not reach the memory.
  assign unused_addr = ^req_addr[ADDR_W-1:MEM_AW+2];

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_n = 3'd1;
      2'b01:   req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
  end

  assign req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                     (req_funct3 == 3'b010) ||
                     (!req_we && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));
  assign req_split = ({1'b0, req_addr[1:0]} + req_n) > 3'd4;
  // Handshake: a request transfers on a clock edge where req_valid && req_ready;
  // responses are single-cycle pulses with no backpressure.
  assign accept    = req_valid && req_ready;

  always_comb begin
    case (f3_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      default: size_mask = 8'h0f;
    endcase
  end

  assign m8      = size_mask << off_q;
  assign d64     = {32'b0, wdata_q} << {off_q, 3'b000};
  assign shifted = 32'({(split_q ? hi_q : 32'b0), lo_q} >> {off_q, 3'b000});

  always_comb begin
    load_result = 32'b0;
    if (!we_q && !err_q) begin
      case (f3_q)
        3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
        3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
        3'b100:  load_result = {24'b0, shifted[7:0]};
        3'b101:  load_result = {16'b0, shifted[15:0]};
        default: load_result = shifted;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      word_q  <= '0;
      wdata_q <= 32'b0;
      lo_q    <= 32'b0;
      hi_q    <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= !req_legal;
        split_q <= req_split;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        word_q  <= req_addr[MEM_AW+1:2];
        wdata_q <= req_wdata;
      end
      // The memory returns data one cycle after the read is issued.
      if (state == ACC1 && !we_q) lo_q <= mem_r_data;
      if (state == WAIT) begin
        if (split_q) hi_q <= mem_r_data;
        else         lo_q <= mem_r_data;
      end
      if (state == RESP) rdata_q <= load_result;
    end
  end

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = rdata_q;
    mem_wren    = 1'b0;
    mem_is_load = 1'b0;
    mem_mask    = 4'b0;
    mem_r_addr  = '0;
    mem_w_addr  = '0;
    mem_w_data  = 32'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_legal ? ACC0 : RESP;
      end
      ACC0: begin
        if (we_q) begin
          mem_wren   = 1'b1;
          mem_w_addr = word_q;
          mem_mask   = m8[3:0];
          mem_w_data = d64[31:0];
        end else begin
          mem_is_load = 1'b1;
          mem_r_addr  = word_q;
        end
        if (split_q)   state_next = ACC1;
        else if (we_q) state_next = RESP;
        else           state_next = WAIT;
      end
      ACC1: begin
        if (we_q) begin
          mem_wren   = 1'b1;
          mem_w_addr = word_q + MEM_AW'(1);
          mem_mask   = m8[7:4];
          mem_w_data = d64[63:32];
        end else begin
          mem_is_load = 1'b1;
          mem_r_addr  = word_q + MEM_AW'(1);
        end
        state_next = we_q ? RESP : WAIT;
      end
      WAIT: state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = load_result;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // No memory access or response on any edge where reset is sampled.
    if (rst) begin
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_err    = 1'b0;
      resp_rdata  = 32'b0;
      mem_wren    = 1'b0;
      mem_is_load = 1'b0;
      mem_mask    = 4'b0;
      mem_r_addr  = '0;
      mem_w_addr  = '0;
      mem_w_data  = 32'b0;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: a word memory model behind the unit, a byte-level reference
// memory, and queues of expected responses, writes and reads checked by one monitor.
module tb_lsu_align;
  localparam int ADDR_W = 32;
  localparam int MEM_AW = 5;
  localparam int RW     = 65;

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic              req_valid  = 1'b0;
  logic              req_we     = 1'b0;
  logic [2:0]        req_funct3 = 3'b0;
  logic [ADDR_W-1:0] req_addr   = '0;
  logic [31:0]       req_wdata  = 32'b0;
  logic              req_ready, resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_wren, mem_is_load;
  logic [3:0]        mem_mask;
  logic [MEM_AW-1:0] mem_r_addr, mem_w_addr;
  logic [31:0]       mem_w_data;
  logic [31:0]       mem_r_data = 32'b0;

  logic [31:0] mem_words [32] = '{default: 32'b0};
  logic [7:0]  ref_bytes [128] = '{default: 8'b0};

  logic [RW-1:0] exp_q[$];   // {err, rdata, due cycle}
  logic [40:0]   wr_q[$];    // {w_addr, mask, w_data}
  logic [4:0]    rd_q[$];    // r_addr

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tmo_cnt = 0;
  int   tmo_seen = 0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;
  logic after_rst = 1'b0;
  logic [31:0] held_exp = 32'b0;

  lsu_align #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wren(mem_wren), .mem_is_load(mem_is_load), .mem_mask(mem_mask),
    .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // data_mem: byte-masked write, registered read
  always @(posedge clk) begin
    if (mem_wren)
      for (int l = 0; l < 4; l++)
        if (mem_mask[l]) mem_words[mem_w_addr][8*l +: 8] <= mem_w_data[8*l +: 8];
    if (mem_is_load) mem_r_data <= mem_words[mem_r_addr];
  end

  // Driver: presents one request, updates the reference memory and the expectations.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic chk, input logic [31:0] want,
                       input logic abort);
    int n, lat, t;
    logic legal, split;
    logic [31:0] a, val, exp_rd;
    logic [3:0] m0, m1;
    logic [4:0] n0;
    logic [63:0] d64;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    t = 0;
    while (!req_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      tmo_cnt++;
      req_valid = 1'b0;
      return;
    end
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    n0 = addr[6:2];
    m0 = 4'b0; m1 = 4'b0; val = 32'b0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (a[6:2] == n0) m0[a[1:0]] = 1'b1;
      else              m1[a[1:0]] = 1'b1;
      val[8*i +: 8] = ref_bytes[a[6:0]];
    end
    split = (m1 != 4'b0);
    if (!abort) begin
      exp_rd = 32'b0;
      if (!legal) lat = 1;
      else if (we) begin
        lat = split ? 3 : 2;
        for (int i = 0; i < n; i++) begin
          a = addr + 32'(i);
          ref_bytes[a[6:0]] = wdata[8*i +: 8];
        end
        d64 = {32'b0, wdata} << (8 * addr[1:0]);
        wr_q.push_back({n0, m0, d64[31:0]});
        if (split) wr_q.push_back({n0 + 5'd1, m1, d64[63:32]});
      end else begin
        lat = split ? 4 : 3;
        case (f3)
          3'b000:  exp_rd = {{24{val[7]}}, val[7:0]};
          3'b001:  exp_rd = {{16{val[15]}}, val[15:0]};
          3'b100:  exp_rd = {24'b0, val[7:0]};
          3'b101:  exp_rd = {16'b0, val[15:0]};
          default: exp_rd = val;
        endcase
        rd_q.push_back(n0);
        if (split) rd_q.push_back(n0 + 5'd1);
      end
      if (chk) exp_rd = want;
      exp_q.push_back({!legal, exp_rd, 32'(cyc + lat)});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [RW-1:0] e;
    logic [40:0]   w;
    logic [4:0]    r;
    if (rst) begin
      checks++;
      if (req_ready || resp_valid || resp_err || resp_rdata != 32'b0 || mem_wren || mem_is_load ||
          mem_mask != 4'b0 || mem_r_addr != '0 || mem_w_addr != '0 || mem_w_data != 32'b0) begin
        errors++;
        $display("FAIL reset_state: ready=%b resp_valid=%b err=%b rdata=%h wren=%b is_load=%b mask=%b waddr=%0d raddr=%0d wdata=%h, required all 0",
                 req_ready, resp_valid, resp_err, resp_rdata, mem_wren, mem_is_load, mem_mask,
                 mem_w_addr, mem_r_addr, mem_w_data);
      end
      held_exp = 32'b0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_reset: got %b required 1", req_ready);
        end
        after_rst = 1'b0;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: rdata=%h err=%b at cycle %0d", resp_rdata, resp_err, cyc);
        end else begin
          e = exp_q.pop_front();
          checks += 3;
          if (resp_rdata !== e[63:32]) begin
            errors++;
            $display("FAIL resp_rdata: got %h required %h", resp_rdata, e[63:32]);
          end
          if (resp_err !== e[64]) begin
            errors++;
            $display("FAIL resp_err: got %b required %b", resp_err, e[64]);
          end
          if (cyc != int'(e[31:0])) begin
            errors++;
            $display("FAIL resp_latency: got cycle %0d required %0d", cyc, e[31:0]);
          end
          held_exp = e[63:32];
        end
      end else begin
        checks++;
        if (resp_rdata !== held_exp) begin
          errors++;
          $display("FAIL resp_hold: got %h required %h", resp_rdata, held_exp);
        end
      end
      if (mem_wren && mem_is_load) begin
        checks++; errors++;
        $display("FAIL wren_and_load: got both 1 required at most one");
      end
      if (mem_wren) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: waddr=%0d mask=%b data=%h", mem_w_addr, mem_mask, mem_w_data);
        end else begin
          w = wr_q.pop_front();
          if ({mem_w_addr, mem_mask, mem_w_data} !== w) begin
            errors++;
            $display("FAIL write_access: got waddr=%0d mask=%b data=%h required waddr=%0d mask=%b data=%h",
                     mem_w_addr, mem_mask, mem_w_data, w[40:36], w[35:32], w[31:0]);
          end
        end
      end
      if (mem_is_load) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected: raddr=%0d", mem_r_addr);
        end else begin
          r = rd_q.pop_front();
          if (mem_r_addr !== r) begin
            errors++;
            $display("FAIL read_addr: got %0d required %0d", mem_r_addr, r);
          end
        end
      end
      if (!mem_wren && !mem_is_load) begin
        checks++;
        if (mem_mask != 4'b0 || mem_r_addr != '0 || mem_w_addr != '0 || mem_w_data != 32'b0) begin
          errors++;
          $display("FAIL idle_mem_outputs: mask=%b raddr=%0d waddr=%0d wdata=%h required all 0",
                   mem_mask, mem_r_addr, mem_w_addr, mem_w_data);
        end
      end
    end
    if (tmo_cnt != tmo_seen) begin
      checks++; errors++;
      $display("FAIL ready_timeout: req_ready stayed 0 for 10 cycles, required 1");
      tmo_seen = tmo_cnt;
    end
    if (final_req && !final_done) begin
      checks += 3;
      if (exp_q.size() != 0) begin
        errors++; $display("FAIL resp_missing: %0d pending, required 0", exp_q.size());
      end
      if (wr_q.size() != 0) begin
        errors++; $display("FAIL write_missing: %0d pending, required 0", wr_q.size());
      end
      if (rd_q.size() != 0) begin
        errors++; $display("FAIL read_missing: %0d pending, required 0", rd_q.size());
      end
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (mem_words[k] !== {ref_bytes[4*k+3], ref_bytes[4*k+2], ref_bytes[4*k+1], ref_bytes[4*k]}) begin
          errors++;
          $display("FAIL mem_word%0d: got %h required %h", k, mem_words[k],
                   {ref_bytes[4*k+3], ref_bytes[4*k+2], ref_bytes[4*k+1], ref_bytes[4*k]});
        end
      end
      final_done = 1'b1;
    end
  end

  // Stimulus
  initial begin
    logic [2:0] f3;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h00, 32'hAABBCCDD, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h04, 32'h11223344, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h02, 32'h0,        1'b1, 32'h3344AABB, 1'b0);
    issue(1'b0, 3'b000, 32'h07, 32'h0,        1'b1, 32'h00000011, 1'b0);
    issue(1'b0, 3'b001, 32'h06, 32'h0,        1'b1, 32'h00001122, 1'b0);
    issue(1'b1, 3'b010, 32'h04, 32'h80FF0000, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'b001, 32'h06, 32'h0,        1'b1, 32'hFFFF80FF, 1'b0);
    issue(1'b0, 3'b101, 32'h06, 32'h0,        1'b1, 32'h000080FF, 1'b0);
    issue(1'b1, 3'b001, 32'h03, 32'h0000ABCD, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h7D, 32'h01020304, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h7F, 32'h0,        1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'b011, 32'h10, 32'h0,        1'b0, 32'h0, 1'b0);
    issue(1'b1, 3'b100, 32'h10, 32'h12345678, 1'b0, 32'h0, 1'b0);

    // Reset during the first half of a split store: nothing may be written.
    issue(1'b1, 3'b010, 32'h05, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      f3 = 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), f3, $urandom, $urandom, 1'b0, 32'h0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    final_req = 1'b1;
    for (int i = 0; i < 5 && !final_done; i++) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
